// File: rtl/alu_mc_pkg.sv
// Shared types and constants for the multicycle ALU (alu_mc) and its multiplier.
package alu_mc_pkg;

  typedef enum logic [2:0] {
    OP_ADD  = 3'b000,
    OP_SUB  = 3'b001,
    OP_AND  = 3'b010,
    OP_ORR  = 3'b011,
    OP_EOR  = 3'b100,
    OP_MUL  = 3'b101,
    OP_RSV6 = 3'b110,
    OP_RSV7 = 3'b111
  } alu_op_t;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_MUL  = 2'd1,
    S_DONE = 2'd2
  } alu_state_t;

  localparam int FLAG_N = 3;
  localparam int FLAG_Z = 2;
  localparam int FLAG_C = 1;
  localparam int FLAG_V = 0;

endpackage

// File: rtl/alu_mc_mul.sv
// Iterative shift-add multiplier, one multiplier bit per cycle, LSB first.
// Optional early termination when the remaining multiplier bits are zero: ALU_MC_MUL_EARLY_TERM_EN.
module alu_mc_mul
  import alu_mc_pkg::*;
#(
  parameter int N = 32
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         load,
  input  logic [N-1:0] A,
  input  logic [N-1:0] B,
  output logic [N-1:0] product,
  output logic         last
);

  localparam int CW = $clog2(N);

  logic [N-1:0]  acc_q, acc_d;
  logic [N-1:0]  mcand_q, mcand_d;
  logic [N-1:0]  mplier_q, mplier_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic          active_q, active_d;
  logic [N-1:0]  partial;
  logic [N-1:0]  mplier_shr;

  // product is the accumulator value after the current iteration, so the top
  // can register it on the same edge that completes the last iteration.
  always_comb begin
    partial    = mplier_q[0] ? mcand_q : '0;
    mplier_shr = mplier_q >> 1;
    product    = acc_q + partial;
`ifdef ALU_MC_MUL_EARLY_TERM_EN
    last       = active_q && ((cnt_q == CW'(N - 1)) || (mplier_shr == '0));
`else
    last       = active_q && (cnt_q == CW'(N - 1));
`endif

    // NOTE: every always_comb output gets a default first so no path leaves a
    // signal unassigned, which would otherwise infer a latch.
    acc_d    = acc_q;
    mcand_d  = mcand_q;
    mplier_d = mplier_q;
    cnt_d    = cnt_q;
    active_d = active_q;

    if (load) begin
      acc_d    = '0;
      mcand_d  = A;
      mplier_d = B;
      cnt_d    = '0;
      active_d = 1'b1;
    end else if (active_q) begin
      acc_d    = product;
      mcand_d  = mcand_q << 1;
      mplier_d = mplier_shr;
      cnt_d    = cnt_q + CW'(1);
      active_d = !last;
    end
  end

  // NOTE: sequential state uses non-blocking assignments so every flop samples
  // pre-edge values regardless of block ordering.
  always_ff @(posedge clk) begin
    if (reset) begin
      acc_q    <= '0;
      mcand_q  <= '0;
      mplier_q <= '0;
      cnt_q    <= '0;
      active_q <= 1'b0;
    end else begin
      acc_q    <= acc_d;
      mcand_q  <= mcand_d;
      mplier_q <= mplier_d;
      cnt_q    <= cnt_d;
      active_q <= active_d;
    end
  end

endmodule

// File: rtl/alu_mc.sv
// Multicycle ALU: ADD/SUB/AND/ORR/EOR single-cycle, MUL iterative, Start/Busy/Done handshake.
// Build option ALU_MC_MUL_EARLY_TERM_EN (handled inside alu_mc_mul) shortens multiplies.
module alu_mc
  import alu_mc_pkg::*;
#(
  parameter int          N          = 32,
  parameter logic [31:0] INST_LIMIT = 32'h3FC
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         Start,
  input  logic [2:0]   ALUControl,
  input  logic [N-1:0] A,
  input  logic [N-1:0] B,
  output logic         Busy,
  output logic         Done,
  output logic [N-1:0] Result,
  output logic [3:0]   ALUFlags,
  output logic         InstMem
);

  localparam int CMP_W = (N > 32) ? N : 32;

  alu_state_t   state_q, state_d;
  logic [N-1:0] result_q, result_d;
  logic [3:0]   flags_q, flags_d;

  alu_op_t      op;
  logic         is_sub;
  logic [N-1:0] b_eff;
  logic [N:0]   sum;
  logic [N-1:0] alu_res;
  logic         alu_c, alu_v;
  logic [3:0]   alu_flags;
  logic [3:0]   mul_flags;
  logic         mul_load, mul_last;
  logic [N-1:0] mul_product;

  alu_mc_mul #(.N(N)) u_mul (
    .clk     (clk),
    .reset   (reset),
    .load    (mul_load),
    .A       (A),
    .B       (B),
    .product (mul_product),
    .last    (mul_last)
  );

  // Single-cycle datapath; SUB adds ~B + 1 so C is the ARM not-borrow.
  always_comb begin
    op     = alu_op_t'(ALUControl);
    is_sub = (op == OP_SUB);
    b_eff  = is_sub ? ~B : B;
    sum    = {1'b0, A} + {1'b0, b_eff} + {{N{1'b0}}, is_sub};

    alu_res = '0;
    alu_c   = 1'b0;
    alu_v   = 1'b0;
    case (op)
      OP_ADD, OP_SUB: begin
        alu_res = sum[N-1:0];
        alu_c   = sum[N];
        alu_v   = ~(is_sub ^ A[N-1] ^ B[N-1]) & (A[N-1] ^ sum[N-1]);
      end
      OP_AND:  alu_res = A & B;
      OP_ORR:  alu_res = A | B;
      OP_EOR:  alu_res = A ^ B;
      default: alu_res = '0;
    endcase

    alu_flags         = '0;
    alu_flags[FLAG_N] = alu_res[N-1];
    alu_flags[FLAG_Z] = (alu_res == '0);
    alu_flags[FLAG_C] = alu_c;
    alu_flags[FLAG_V] = alu_v;

    mul_flags         = '0;
    mul_flags[FLAG_N] = mul_product[N-1];
    mul_flags[FLAG_Z] = (mul_product == '0);
  end

  always_comb begin
    state_d  = state_q;
    result_d = result_q;
    flags_d  = flags_q;
    mul_load = 1'b0;

    case (state_q)
      S_IDLE, S_DONE: begin
        if (Start) begin
          if (op == OP_MUL) begin
            mul_load = 1'b1;
            state_d  = S_MUL;
          end else begin
            result_d = alu_res;
            flags_d  = alu_flags;
            state_d  = S_DONE;
          end
        end else begin
          state_d = S_IDLE;
        end
      end
      S_MUL: begin
        // Start is ignored here; Result/flags hold until the final iteration.
        if (mul_last) begin
          result_d = mul_product;
          flags_d  = mul_flags;
          state_d  = S_DONE;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q  <= S_IDLE;
      result_q <= '0;
      flags_q  <= '0;
    end else begin
      state_q  <= state_d;
      result_q <= result_d;
      flags_q  <= flags_d;
    end
  end

  assign Busy     = (state_q == S_MUL);
  assign Done     = (state_q == S_DONE);
  assign Result   = result_q;
  assign ALUFlags = flags_q;
  assign InstMem  = (CMP_W'(result_q) <= CMP_W'(INST_LIMIT));

endmodule

// File: tb/tb_alu_mc.sv
// Directed self-checking bench for alu_mc (N=32) with hand-computed expected values.
module tb_alu_mc;

  localparam logic [2:0] ADD = 3'b000, SUB = 3'b001, AND_ = 3'b010, ORR = 3'b011,
                         EOR = 3'b100, MUL = 3'b101, RSV = 3'b110;
`ifdef ALU_MC_MUL_EARLY_TERM_EN
  localparam int MUL_BIG = 17;
  localparam int MUL_ONE = 1;
`else
  localparam int MUL_BIG = 32;
  localparam int MUL_ONE = 32;
`endif

  logic        clk = 1'b0;
  logic        reset, Start;
  logic [2:0]  ALUControl;
  logic [31:0] A, B;
  logic        Busy, Done, InstMem;
  logic [31:0] Result;
  logic [3:0]  ALUFlags;

  int n_tests = 0;
  int n_fail  = 0;

  alu_mc dut (
    .clk        (clk),
    .reset      (reset),
    .Start      (Start),
    .ALUControl (ALUControl),
    .A          (A),
    .B          (B),
    .Busy       (Busy),
    .Done       (Done),
    .Result     (Result),
    .ALUFlags   (ALUFlags),
    .InstMem    (InstMem)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  // Issue one op; cyc returns the cycle (relative to the Start edge) where Done is seen.
  task automatic run_op(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b,
                        output int cyc);
    Start = 1'b1; ALUControl = op; A = a; B = b;
    tick;
    Start = 1'b0;
    cyc = 1;
    while (!Done && cyc < 60) begin
      tick;
      cyc++;
    end
  endtask

  initial begin
    int cyc;
    int n_busy;
    int n_done;

    reset = 1'b1; Start = 1'b0; ALUControl = ADD; A = '0; B = '0;
    tick; tick;
    reset = 1'b0;
    tick;
    check("rst_result", Result, 32'h0);
    check("rst_flags", ALUFlags, 4'b0000);
    check("rst_done", Done, 1'b0);
    check("rst_busy", Busy, 1'b0);
    check("rst_instmem", InstMem, 1'b1);

    run_op(ADD, 32'h7FFF_FFFF, 32'h1, cyc);
    check("add_lat", cyc, 1);
    check("add_result", Result, 32'h8000_0000);
    check("add_flags", ALUFlags, 4'b1001);
    check("add_instmem", InstMem, 1'b0);
    tick;
    check("done_one_cycle", Done, 1'b0);
    check("add_hold", Result, 32'h8000_0000);

    run_op(SUB, 32'h5, 32'h5, cyc);
    check("sub_eq_result", Result, 32'h0);
    check("sub_eq_flags", ALUFlags, 4'b0110);
    run_op(SUB, 32'h0, 32'h1, cyc);
    check("sub_borrow_result", Result, 32'hFFFF_FFFF);
    check("sub_borrow_flags", ALUFlags, 4'b1000);
    run_op(ADD, 32'hFFFF_FFFF, 32'h1, cyc);
    check("add_carry_result", Result, 32'h0);
    check("add_carry_flags", ALUFlags, 4'b0110);
    run_op(RSV, 32'h12, 32'h34, cyc);
    check("rsv_lat", cyc, 1);
    check("rsv_result", Result, 32'h0);
    check("rsv_flags", ALUFlags, 4'b0100);
    run_op(AND_, 32'h0000_F0F0, 32'h0000_FF00, cyc);
    check("and_result", Result, 32'h0000_F000);
    check("and_flags", ALUFlags, 4'b0000);
    tick;

    // Long multiply with an ignored ADD request mid-run.
    Start = 1'b1; ALUControl = MUL; A = 32'h0000_FFFF; B = 32'h0001_0001;
    tick;
    Start = 1'b0;
    cyc = 1; n_busy = 0;
    while (!Done && cyc < 60) begin
      if (Busy) n_busy++;
      if (cyc == 5) begin
        Start = 1'b1; ALUControl = ADD; A = 32'h1; B = 32'h1;
      end else begin
        Start = 1'b0;
      end
      if (cyc == 3) check("mul_result_hold", Result, 32'h0000_F000);
      tick;
      cyc++;
    end
    check("mul_lat", cyc, MUL_BIG + 1);
    check("mul_busy_cycles", n_busy, MUL_BIG);
    check("mul_result", Result, 32'hFFFF_FFFF);
    check("mul_flags", ALUFlags, 4'b1000);
    check("mul_busy_at_done", Busy, 1'b0);
    tick;
    check("mul_no_queue", Done, 1'b0);
    check("mul_result_kept", Result, 32'hFFFF_FFFF);

    run_op(MUL, 32'h1234_5678, 32'h1, cyc);
    check("mul_b1_lat", cyc, MUL_ONE + 1);
    check("mul_b1_result", Result, 32'h1234_5678);
    check("mul_b1_flags", ALUFlags, 4'b0000);

    // Reset during the 5th multiply cycle discards the operation.
    Start = 1'b1; ALUControl = MUL; A = 32'h7; B = 32'h9;
    tick;
    Start = 1'b0;
    repeat (4) tick;
    reset = 1'b1;
    tick;
    reset = 1'b0;
    check("mrst_result", Result, 32'h0);
    check("mrst_flags", ALUFlags, 4'b0000);
    check("mrst_busy", Busy, 1'b0);
    check("mrst_instmem", InstMem, 1'b1);
    n_done = 0;
    repeat (40) begin
      if (Done) n_done++;
      tick;
    end
    check("mrst_no_done", n_done, 0);

    // Start together with reset is dropped.
    Start = 1'b1; ALUControl = ADD; A = 32'h1; B = 32'h1; reset = 1'b1;
    tick;
    reset = 1'b0; Start = 1'b0;
    check("rst_start_done", Done, 1'b0);
    tick;
    check("rst_start_done2", Done, 1'b0);
    check("rst_start_result", Result, 32'h0);

    run_op(ORR, 32'h0000_03F0, 32'h0000_000C, cyc);
    check("orr_lat", cyc, 1);
    check("orr_result", Result, 32'h0000_03FC);
    check("orr_instmem", InstMem, 1'b1);
    check("orr_flags", ALUFlags, 4'b0000);
    tick;

    // Back-to-back: ADD held during the EOR DONE cycle.
    Start = 1'b1; ALUControl = EOR; A = 32'hFF00_FF00; B = 32'h0F0F_0F0F;
    tick;
    check("eor_done", Done, 1'b1);
    check("eor_result", Result, 32'hF00F_F00F);
    check("eor_flags", ALUFlags, 4'b1000);
    ALUControl = ADD; A = 32'h2; B = 32'h3;
    tick;
    Start = 1'b0;
    check("b2b_done", Done, 1'b1);
    check("b2b_result", Result, 32'h5);
    check("b2b_flags", ALUFlags, 4'b0000);
    tick;
    check("b2b_idle", Done, 1'b0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/alu_mc.md
Name: alu_mc

Overview:
- Parametrised multicycle successor to the datapath ALU.
- Adds EOR and an iterative N-bit multiply to ADD/SUB/AND/ORR.
- Registers Result and ALUFlags and uses a Start/Busy/Done handshake, so the datapath control FSM can stall on long operations.
- Keeps the instruction-memory range flag (InstMem) for address decode.

Parameters:
- N, 32, operand/result width (>= 4).
- INST_LIMIT, 32'h3FC, highest byte address that is still instruction memory; compared against Result.

Ports:
- clk  input  1  rising-edge clock.
- reset  input  1  synchronous, active-high reset.
- Start  input  1  request; sampled only when the unit can accept.
- ALUControl  input  3  opcode, sampled with Start.
- A  input  N  operand A, sampled with Start.
- B  input  N  operand B, sampled with Start.
- Busy  output  1  high while a multiply iterates.
- Done  output  1  one-cycle completion pulse.
- Result  output  N  registered result; holds until the next completion.
- ALUFlags  output  4  registered {N, Z, C, V}; holds with Result.
- InstMem  output  1  combinational: Result <= INST_LIMIT (unsigned compare, zero-extended).

Behaviour:
- Opcodes: 000 ADD, 001 SUB, 010 AND, 011 ORR, 100 EOR, 101 MUL. 110 and 111 are reserved.
- FSM states: IDLE, MUL, DONE.
- Start is accepted in IDLE or DONE (back-to-back supported). Start in MUL is ignored, with no queuing.
- On accept, A, B and opcode are latched.
  - Non-MUL opcode: compute and register Result/ALUFlags; next state DONE.
  - MUL: load the internal accumulator and counter; next state MUL.
- Latency, with Start sampled at edge k:
  - Single-cycle ops: Done=1 during cycle k+1.
  - MUL: exactly N iterations in MUL, Done=1 during cycle k+N+1.
- DONE lasts one cycle. It returns to IDLE unless Start is present, in which case the new operation begins.
- Busy = (state == MUL).
- ADD/SUB: {C, Result} = {0,A} + {0, SUB ? ~B : B} + SUB.
  - C is the ARM carry, so SUB carry = NOT borrow.
  - V = ~(SUB ^ A[N-1] ^ B[N-1]) & (A[N-1] ^ Result[N-1]).
- AND/ORR/EOR/MUL: C=0, V=0.
- MUL result: shift-add, one multiplier bit per cycle, LSB first. Result is the low N bits of A*B (unsigned; equal to the signed low half).
- N flag = Result[N-1]. Z flag = (Result == 0). Both are computed for every opcode.
- Reserved opcodes: Result=0, ALUFlags=4'b0100, Done next cycle like a single-cycle op.
- Result and ALUFlags change only on the completion edge. During MUL they keep their previous values.
- Reset at any time, including mid-multiply:
  - state=IDLE, Result=0, ALUFlags=0, Done=0, Busy=0, accumulator and counter cleared.
  - InstMem therefore reads 1 after reset.
  - The in-flight operation is discarded with no Done.
- Start together with reset: reset wins; the request is dropped.

Optional Feature:
- Macro ALU_MC_MUL_EARLY_TERM_EN.
- Defined: MUL finishes in the first cycle where the remaining shifted multiplier bits are all zero, minimum 1 iteration. B=0 or B=1 gives Done at k+2. Result and flags are identical to the full run.
- Undefined: MUL always takes exactly N iterations, as specified above.

Decomposition:
- Package alu_mc_pkg holds:
  - alu_op_t enum (3-bit opcodes above);
  - alu_state_t enum (IDLE/MUL/DONE);
  - flag index localparams FLAG_N=3, FLAG_Z=2, FLAG_C=1, FLAG_V=0.
- One sub-module, alu_mc_mul:
  - contains the iterative shift-add multiplier;
  - inputs: clk, reset, load, A, B;
  - outputs: product, last;
  - parameter N;
  - implements the early-termination macro internally.
- Top level holds the FSM, single-cycle datapath, flag logic and InstMem compare.

Test Plan:
- Reset then idle (N=32): Result=0, ALUFlags=0000, Done=0, Busy=0, InstMem=1.
- ADD A=32'h7FFFFFFF, B=1: Done at k+1, Result=32'h80000000, flags N=1 Z=0 C=0 V=1, InstMem=0.
- SUB A=5, B=5: Result=0, flags 0110. Then SUB A=0, B=1: Result=32'hFFFFFFFF, flags 1000.
- MUL A=32'h0000FFFF, B=32'h00010001:
  - Busy for 32 cycles, Done at k+33, Result=32'hFFFFFFFF, flags 1000.
  - A Start mid-run with an ADD opcode is ignored.
- MUL A=7, B=9, reset asserted at the 5th MUL cycle: no Done, Result=0. A following ORR A=32'h3F0, B=32'h00C gives Result=32'h3FC, InstMem=1, Done at k+1.
- Back-to-back: ADD Start held during the DONE cycle of a previous EOR → two Done pulses on consecutive cycles. With ALU_MC_MUL_EARLY_TERM_EN, MUL B=1 gives Done at k+2.
